// File: rtl/equiv_stim_gen_if.sv
// Bundle of run-control, DUT-pair observation and stimulus signals for equiv_stim_gen.
// master = run controller / DUT-pair side, slave = the generator itself.
interface equiv_stim_gen_if;
  logic               start;
  logic [31:0]        seed;
  logic [15:0]        num_vectors;
  logic [90:0]        y_1;
  logic [90:0]        y_2;
  logic [21:0]        wire0;
  logic [5:0]         wire1;
  logic signed [14:0] wire2;
  logic [20:0]        wire3;
  logic [11:0]        wire4;
  logic               busy;
  logic               done;
  logic [15:0]        vec_count;
  logic [15:0]        mismatch_count;
  logic [15:0]        first_mismatch_idx;

  modport master (
    output start, seed, num_vectors, y_1, y_2,
    input  wire0, wire1, wire2, wire3, wire4,
    input  busy, done, vec_count, mismatch_count, first_mismatch_idx
  );

  modport slave (
    input  start, seed, num_vectors, y_1, y_2,
    output wire0, wire1, wire2, wire3, wire4,
    output busy, done, vec_count, mismatch_count, first_mismatch_idx
  );
endinterface

// File: rtl/equiv_stim_gen.sv
// LFSR-driven stimulus generator for a pair of DUT copies; counts y_1/y_2 mismatches per vector.
// Optional macro MISMATCH_STOP_EN: end the run at the first counted mismatch.
module equiv_stim_gen #(
  parameter logic [31:0] LFSR_POLY = 32'h80200003,
  parameter int unsigned WARMUP    = 2
) (
  input logic              clk,
  input logic              rst,
  equiv_stim_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StGen0,
    StGen1,
    StGen2,
    StApply,
    StDone
  } state_e;

  state_e             r_state;
  logic [31:0]        r_lfsr;
  logic [31:0]        r_w0;
  logic [31:0]        r_w1;
  logic [15:0]        r_num_vec;
  logic [21:0]        r_wire0;
  logic [5:0]         r_wire1;
  logic signed [14:0] r_wire2;
  logic [20:0]        r_wire3;
  logic [11:0]        r_wire4;
  logic               r_busy;
  logic               r_done;
  logic [15:0]        r_vec_count;
  logic [15:0]        r_mismatch_count;
  logic [15:0]        r_first_idx;

  logic [31:0] w_lfsr_next;
  logic [15:0] w_vec_inc;
  logic        w_mismatch;
  logic        w_stop;
  logic [75:0] w_vec;

  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : 32'h0);
  assign w_vec_inc   = r_vec_count + 16'd1;
  assign w_mismatch  = ({16'd0, r_vec_count} >= WARMUP) && (bus.y_1 != bus.y_2);
  // Third word is consumed straight from the stepping LFSR; only its low 12 bits are needed.
  assign w_vec       = {w_lfsr_next[11:0], r_w1, r_w0};

`ifdef MISMATCH_STOP_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= StIdle;
      r_lfsr           <= 32'h0;
      r_w0             <= 32'h0;
      r_w1             <= 32'h0;
      r_num_vec        <= 16'h0;
      r_wire0          <= '0;
      r_wire1          <= '0;
      r_wire2          <= '0;
      r_wire3          <= '0;
      r_wire4          <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_vec_count      <= 16'h0;
      r_mismatch_count <= 16'h0;
      r_first_idx      <= 16'hFFFF;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (bus.start) begin
            if (bus.num_vectors == 16'h0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state          <= StGen0;
              r_lfsr           <= (bus.seed == 32'h0) ? 32'h1 : bus.seed;
              r_num_vec        <= bus.num_vectors;
              r_vec_count      <= 16'h0;
              r_mismatch_count <= 16'h0;
              r_first_idx      <= 16'hFFFF;
              r_busy           <= 1'b1;
            end
          end
        end
        StGen0: begin
          r_lfsr  <= w_lfsr_next;
          r_w0    <= w_lfsr_next;
          r_state <= StGen1;
        end
        StGen1: begin
          r_lfsr  <= w_lfsr_next;
          r_w1    <= w_lfsr_next;
          r_state <= StGen2;
        end
        StGen2: begin
          r_lfsr  <= w_lfsr_next;
          r_wire0 <= w_vec[21:0];
          r_wire1 <= w_vec[27:22];
          r_wire2 <= w_vec[42:28];
          r_wire3 <= w_vec[63:43];
          r_wire4 <= w_vec[75:64];
          r_state <= StApply;
        end
        StApply: begin
          if (w_mismatch) begin
            if (r_mismatch_count != 16'hFFFF) begin
              r_mismatch_count <= r_mismatch_count + 16'd1;
            end
            if (r_first_idx == 16'hFFFF) begin
              r_first_idx <= r_vec_count;
            end
          end
          r_vec_count <= w_vec_inc;
          if ((w_vec_inc == r_num_vec) || w_stop) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= StGen0;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.wire0              = r_wire0;
  assign bus.wire1              = r_wire1;
  assign bus.wire2              = r_wire2;
  assign bus.wire3              = r_wire3;
  assign bus.wire4              = r_wire4;
  assign bus.busy               = r_busy;
  assign bus.done               = r_done;
  assign bus.vec_count          = r_vec_count;
  assign bus.mismatch_count     = r_mismatch_count;
  assign bus.first_mismatch_idx = r_first_idx;

endmodule

// File: doc/equiv_stim_gen.md
Name: equiv_stim_gen

Overview:
- Stimulus-side counterpart of the equivalence harness: drives the shared inputs wire0..wire4 of the two DUT copies with an LFSR-derived pseudo-random vector sequence.
- Samples the pair of DUT outputs y_1/y_2 once per vector and counts mismatches.
- Sits above the harness in the fuzz bench; lets a run complete without an external driver and reports a pass/fail summary.

Parameters:
- LFSR_POLY, 32'h80200003, Galois right-shift tap mask for the 32-bit LFSR.
- WARMUP, 2, number of initial vectors whose y comparison is ignored (DUT register fill).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle run request; sampled only in IDLE.
- seed  input  32  LFSR seed, latched on accepted start.
- num_vectors  input  16  number of vectors in the run.
- y_1  input  91  output of DUT copy 1.
- y_2  input  91  output of DUT copy 2.
- wire0  output  22  stimulus.
- wire1  output  6  stimulus.
- wire2  output  15 (signed)  stimulus.
- wire3  output  21  stimulus.
- wire4  output  12  stimulus.
- busy  output  1  high from the cycle after an accepted start until DONE.
- done  output  1  one-cycle pulse at end of run.
- vec_count  output  16  vectors applied in the current/last run.
- mismatch_count  output  16  compared vectors with y_1 != y_2; saturates at 16'hFFFF.
- first_mismatch_idx  output  16  vec_count value (pre-increment) of the first mismatch; 16'hFFFF if none.

Behaviour:
- Reset (async, any state): state=IDLE; all wire*, vec_count, mismatch_count = 0; busy=done=0; first_mismatch_idx=16'hFFFF; LFSR=0.
- LFSR step: lsb=L[0]; L = (L>>1) ^ (lsb ? LFSR_POLY : 0).
- Seed load: on accepted start, L=seed; seed==0 is replaced by 32'h1.
- States: IDLE, GEN0, GEN1, GEN2, APPLY, DONE.
- IDLE, start=1:
  - num_vectors==0 -> DONE.
  - else -> GEN0; clear vec_count and mismatch_count; first_mismatch_idx=FFFF.
- GEN0, GEN1, GEN2: one LFSR step per cycle; the stepped value is stored as w0, w1, w2 respectively. wire* hold their previous values throughout.
- GEN2 -> APPLY edge: V={w2,w1,w0}[75:0] is loaded into the outputs:
  - wire0=V[21:0], wire1=V[27:22], wire2=V[42:28], wire3=V[63:43], wire4=V[75:64].
- APPLY, one cycle; at the edge leaving APPLY:
  - If vec_count>=WARMUP and y_1!=y_2: mismatch_count++ (saturating); first_mismatch_idx=vec_count if it is still FFFF.
  - vec_count++.
  - Next state: DONE if the new vec_count==num_vectors, else GEN0.
- Cadence: each vector takes 4 cycles and is held 4 cycles. The compare sees y one full cycle after the vector is applied.
- DONE: done=1, busy=0 for one cycle -> IDLE. Counters hold until the next accepted start.
- start asserted outside IDLE: ignored. seed and num_vectors are sampled only at accepted start.
- Reset mid-run: immediate abort to IDLE with reset values; no done pulse.

Optional Feature:
- Macro: MISMATCH_STOP_EN.
- Defined: a counted mismatch at the APPLY exit edge sends the FSM straight to DONE. vec_count still increments; mismatch_count is then 1.
- Undefined: the run always completes num_vectors vectors; mismatch_count accumulates.

Test Plan:
- seed=0, num_vectors=1, y_1=y_2=0 -> w0=0x80200003, w1=0xC0300002, w2=0x60180001; wire0=0x200003, wire4=0x001; done pulses 5 cycles after start; vec_count=1, mismatch_count=0.
- seed=0x12345678, num_vectors=10, y_1=y_2 -> busy 40 cycles; vec_count=10; mismatch_count=0; first_mismatch_idx=0xFFFF.
- num_vectors=8; y_2=y_1^1 forced during vectors 1 and 5 only (WARMUP=2) -> vector 1 ignored; mismatch_count=1; first_mismatch_idx=5; with MISMATCH_STOP_EN, done after vector 5 with vec_count=6.
- num_vectors=0 -> done pulses the cycle after start; busy never rises; wire* unchanged.
- start pulsed again during a run with num_vectors=4 -> ignored; a single done pulse with vec_count=4.
- rst asserted during GEN1 of vector 3 -> all outputs at reset values that same cycle; next start with the same seed reproduces the identical vector sequence.
